// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared frame geometry and state type for the I2S transmitter
package i2s_pkg;
    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } i2s_state_e;
endpackage

// File: rtl/i2s_bit_timer.sv
// rtl/i2s_bit_timer.sv - divides mclk strobes into the sclk square wave
module i2s_bit_timer #(
    parameter int SCLK_DIV = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic tick_i,
    output logic sclk_o,
    output logic fall_evt_o
);
    localparam int CW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCLK_DIV - 1);

    logic [CW-1:0] div_cnt_q;
    logic          sclk_q;
    logic          wrap;

    assign wrap       = tick_i && (div_cnt_q == LAST);
    // The toggle happening this cycle is a 1->0 edge when sclk is currently high.
    assign fall_evt_o = wrap & sclk_q;
    assign sclk_o     = sclk_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
        end else if (clear_i) begin
            div_cnt_q <= '0;
            sclk_q    <= 1'b0;
        end else if (tick_i) begin
            if (wrap) begin
                div_cnt_q <= '0;
                sclk_q    <= ~sclk_q;
            end else begin
                div_cnt_q <= div_cnt_q + CW'(1);
            end
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S transmit serializer with one-sample holding register
module i2s_tx import i2s_pkg::*; #(
    parameter int WIDTH    = 16,
    parameter int SCLK_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             mclk_stb_i,
    input  logic             lrck_stb_i,
    input  logic             s_valid_i,
    input  logic [WIDTH-1:0] s_left_i,
    input  logic [WIDTH-1:0] s_right_i,
    output logic             s_ready_o,
    output logic             sclk_o,
    output logic             lrclk_o,
    output logic             sdata_o,
    output logic             busy_o,
    output logic             underrun_o,
    output logic             frame_err_o
);
    localparam int PAD = SLOT_BITS - WIDTH;
    localparam logic [5:0] LAST_BIT  = 6'(FRAME_BITS - 1);
    localparam logic [5:0] LR_SWITCH = 6'(SLOT_BITS - 1);

    i2s_state_e             state_q;
    logic                   hold_full_q;
    logic [WIDTH-1:0]       hold_l_q;
    logic [WIDTH-1:0]       hold_r_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [5:0]             bit_q;
    logic                   lrclk_q;
    logic                   sdata_q;
    logic                   underrun_q;
    logic                   frame_err_q;

    logic                   timer_tick;
    logic                   fall_evt;
    logic                   s_xfer;
    logic [FRAME_BITS-1:0]  frame_d;

    // A frame start swallows any coincident mclk strobe.
    assign timer_tick = mclk_stb_i & ~lrck_stb_i & (state_q == RUN);
    assign s_xfer     = s_valid_i & ~hold_full_q;
    assign frame_d    = hold_full_q ? {hold_l_q, {PAD{1'b0}}, hold_r_q, {PAD{1'b0}}}
                                    : '0;

    i2s_bit_timer #(
        .SCLK_DIV (SCLK_DIV)
    ) u_bit_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (lrck_stb_i),
        .tick_i     (timer_tick),
        .sclk_o     (sclk_o),
        .fall_evt_o (fall_evt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            shift_q     <= '0;
            bit_q       <= '0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (lrck_stb_i) begin
                state_q     <= RUN;
                shift_q     <= frame_d;
                bit_q       <= '0;
                lrclk_q     <= 1'b0;
                sdata_q     <= 1'b0;
                hold_full_q <= 1'b0;
                underrun_q  <= ~hold_full_q;
                frame_err_q <= (state_q == RUN);
            end else if (fall_evt) begin
                if (bit_q == LAST_BIT) begin
                    state_q <= IDLE;
                    bit_q   <= '0;
                    lrclk_q <= 1'b0;
                    sdata_q <= 1'b0;
                end else begin
                    // One-bit I2S delay: word select flips one bit ahead of the right MSB.
                    bit_q   <= bit_q + 6'd1;
                    lrclk_q <= (bit_q >= LR_SWITCH);
                    sdata_q <= shift_q[FRAME_BITS-1];
                    shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
                end
            end
            if (s_xfer) begin
                hold_l_q    <= s_left_i;
                hold_r_q    <= s_right_i;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign s_ready_o   = ~hold_full_q;
    assign lrclk_o     = lrclk_q;
    assign sdata_o     = sdata_q;
    assign busy_o      = (state_q == RUN);
    assign underrun_o  = underrun_q;
    assign frame_err_o = frame_err_q;
endmodule

// File: tb/tb_i2s_tx.sv
// tb/tb_i2s_tx.sv - directed and randomized bench for i2s_tx
module tb_i2s_tx;
    localparam int W  = 16;
    localparam int SD = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mclk_stb = 1'b0;
    logic         lrck_stb = 1'b0;
    logic         s_valid = 1'b0;
    logic [W-1:0] s_left = '0;
    logic [W-1:0] s_right = '0;
    logic         s_ready, sclk, lrclk, sdata, busy, underrun, frame_err;

    i2s_tx #(.WIDTH(W), .SCLK_DIV(SD)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .mclk_stb_i  (mclk_stb),
        .lrck_stb_i  (lrck_stb),
        .s_valid_i   (s_valid),
        .s_left_i    (s_left),
        .s_right_i   (s_right),
        .s_ready_o   (s_ready),
        .sclk_o      (sclk),
        .lrclk_o     (lrclk),
        .sdata_o     (sdata),
        .busy_o      (busy),
        .underrun_o  (underrun),
        .frame_err_o (frame_err)
    );

    always #5 clk = ~clk;

    int           n_pass = 0, n_fail = 0, n_total = 0;
    int           mcnt = 0;
    logic         prev_sclk = 1'b0;
    logic [1:0]   rises[$];
    logic         hold_full_m = 1'b0;
    logic [2*W-1:0] hold_m = '0, frame_m = '0, fr;
    int           urun_cnt = 0, ferr_cnt = 0, xfer_cnt = 0, ready_low_cnt = 0;
    bit           cont = 1'b0;
    int           cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: strobe every 4th cycle, reference model of the holding register, sclk-rise capture.
    task automatic tick(input bit lr);
        bit xfer;
        mclk_stb = (mcnt == 3);
        mcnt     = (mcnt + 1) % 4;
        lrck_stb = lr;
        xfer     = s_valid && !hold_full_m;
        if (lr) begin
            frame_m     = hold_full_m ? hold_m : '0;
            hold_full_m = 1'b0;
            rises.delete();
        end
        if (xfer) begin
            hold_m      = {s_left, s_right};
            hold_full_m = 1'b1;
            xfer_cnt++;
        end
        @(posedge clk);
        #1;
        mclk_stb = 1'b0;
        lrck_stb = 1'b0;
        if (!prev_sclk && sclk) rises.push_back({lrclk, sdata});
        prev_sclk = sclk;
        urun_cnt += int'(underrun);
        ferr_cnt += int'(frame_err);
        if (!s_ready) ready_low_cnt++;
        if (xfer) begin
            if (cont) begin
                s_left  = W'($urandom);
                s_right = W'($urandom);
            end else begin
                s_valid = 1'b0;
            end
        end
    endtask

    task automatic offer(input logic [W-1:0] l, input logic [W-1:0] r);
        s_left  = l;
        s_right = r;
        s_valid = 1'b1;
    endtask

    task automatic clear_counts();
        urun_cnt = 0; ferr_cnt = 0; xfer_cnt = 0; ready_low_cnt = 0;
    endtask

    task automatic run_frame(output int c);
        tick(1'b1);
        chk("busy_at_start", busy, 1);
        c = 0;
        while (busy && c < 1100) begin
            tick(1'b0);
            c++;
        end
    endtask

    // Expected {lrclk, sdata} at the n-th sclk rise of a frame carrying f.
    function automatic logic [1:0] exp_bit(input int n, input logic [2*W-1:0] f);
        logic [31:0] slot;
        logic        d;
        if (n == 0) return 2'b00;
        if (n <= 32) begin
            slot = {f[2*W-1:W], 16'h0};
            d    = slot[32-n];
        end else begin
            slot = {f[W-1:0], 16'h0};
            d    = slot[64-n];
        end
        return {(n >= 32), d};
    endfunction

    task automatic check_frame(input string tag, input logic [2*W-1:0] f);
        chk({tag, "_nrises"}, rises.size(), 64);
        for (int n = 0; n < rises.size() && n < 64; n++)
            chk($sformatf("%s_b%0d", tag, n), rises[n], exp_bit(n, f));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {s_ready, sclk, lrclk, sdata, busy, underrun, frame_err}, 7'b1000000);
        rst_n = 1'b1;
        tick(1'b0);

        // Reset mid-frame
        offer(W'($urandom), W'($urandom));
        tick(1'b0);
        tick(1'b1);
        cyc = 0;
        while (rises.size() < 21 && cyc < 1100) begin tick(1'b0); cyc++; end
        chk("midreset_reached_b20", rises.size(), 21);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {s_ready, sclk, lrclk, sdata, busy, underrun, frame_err}, 7'b1000000);
        hold_full_m = 1'b0;
        prev_sclk   = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rises.delete();
        repeat (60) tick(1'b0);
        chk("midreset_no_sclk", rises.size(), 0);
        chk("midreset_idle", busy, 0);

        // Directed frame A5F0 / 0F0F
        clear_counts();
        offer(16'hA5F0, 16'h0F0F);
        tick(1'b0);
        chk("hold_full_ready_low", s_ready, 0);
        run_frame(cyc);
        fr = frame_m;
        chk("frame_data_model", fr, 32'hA5F00F0F);
        chk("busy_duration", (cyc >= 1021 && cyc <= 1024), 1);
        check_frame("directed", fr);
        chk("directed_no_underrun", urun_cnt, 0);
        chk("directed_ready_back", s_ready, 1);

        // Random frames
        for (int k = 0; k < 2; k++) begin
            clear_counts();
            offer(W'($urandom), W'($urandom));
            repeat ($urandom_range(1, 7)) tick(1'b0);
            run_frame(cyc);
            fr = frame_m;
            check_frame($sformatf("rand%0d", k), fr);
            chk("rand_no_underrun", urun_cnt, 0);
            chk("rand_no_ferr", ferr_cnt, 0);
        end

        // Underrun
        clear_counts();
        run_frame(cyc);
        check_frame("underrun", 32'h0);
        chk("underrun_pulses", urun_cnt, 1);
        chk("underrun_ready_stays", ready_low_cnt, 0);

        // Restart at b=40 with a new sample in the hold register
        clear_counts();
        offer(W'($urandom), W'($urandom));
        tick(1'b0);
        tick(1'b1);
        offer(W'($urandom), W'($urandom));
        cyc = 0;
        while (rises.size() < 41 && cyc < 1100) begin tick(1'b0); cyc++; end
        chk("restart_reached_b40", rises.size(), 41);
        tick(1'b1);
        fr = frame_m;
        chk("restart_frame_err", ferr_cnt, 1);
        chk("restart_lr_sclk", {lrclk, sclk, busy}, 3'b001);
        cyc = 0;
        while (busy && cyc < 1100) begin tick(1'b0); cyc++; end
        check_frame("restart", fr);
        chk("restart_no_underrun", urun_cnt, 0);

        // lrck_stb coincident with mclk_stb
        clear_counts();
        while (mcnt != 3) tick(1'b0);
        tick(1'b1);
        cyc = 0;
        while (!sclk && cyc < 100) begin tick(1'b0); cyc++; end
        chk("aligned_first_rise", cyc, 4 * SD);
        while (busy && cyc < 1200) begin tick(1'b0); cyc++; end
        check_frame("aligned", frame_m);

        // Back-to-back frames every 257 strobes with continuous s_valid
        cont = 1'b1;
        offer(W'($urandom), W'($urandom));
        tick(1'b0);
        for (int f = 0; f < 3; f++) begin
            clear_counts();
            tick(1'b1);
            fr = frame_m;
            repeat (257 * 4 - 1) tick(1'b0);
            check_frame($sformatf("b2b%0d", f), fr);
            chk("b2b_one_sample", xfer_cnt, 1);
            chk("b2b_no_underrun", urun_cnt, 0);
            chk("b2b_no_ferr", ferr_cnt, 0);
        end
        cont    = 1'b0;
        s_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
